// File: rtl/split_stream_checker.sv
// Serial evaluator for one split of a partitioned constraint: accumulates a frame of
// NUM_VARS variable beats and returns one verdict per frame over a valid/ready port.
module split_stream_checker #(
  parameter int NUM_VARS = 50,
  parameter int DATA_W   = 8,
  parameter int CNT_W    = $clog2(NUM_VARS + 1) + 1,
  parameter int SUM_W    = DATA_W + $clog2(NUM_VARS) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        cfg_mode,
  input  logic [SUM_W-1:0]  cfg_bound,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_x,
  output logic              out_err,
  output logic [CNT_W-1:0]  out_count
);

  typedef enum logic {
    S_COLLECT = 1'b0,
    S_HOLD    = 1'b1
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [SUM_W-1:0]    r_sum;
  logic [DATA_W-1:0]   r_max;
  logic                r_nzp;
  logic [1:0]          r_mode;
  logic [SUM_W-1:0]    r_bound;
  logic                r_x;
  logic                r_err;
  logic [CNT_W-1:0]    r_count;

  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [SUM_W-1:0]    w_sum_nxt;
  logic [DATA_W-1:0]   w_max_nxt;
  logic                w_nzp_nxt;
  logic                w_first;
  logic [1:0]          w_mode;
  logic [SUM_W-1:0]    w_bound;
  logic                w_err;
  logic                w_x;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [SUM_W:0] s;
    s = {1'b0, a} + {{(SUM_W + 1 - DATA_W){1'b0}}, b};
    return s[SUM_W] ? '1 : s[SUM_W-1:0];
  endfunction

  assign in_ready  = (r_state == S_COLLECT);
  assign out_valid = (r_state == S_HOLD);
  assign out_x     = r_x;
  assign out_err   = r_err;
  assign out_count = r_count;

  // The first beat of a frame evaluates against the live config it is latching,
  // so a one-beat frame still sees the right mode and bound.
  always_comb begin
    w_cnt_nxt = sat_inc(r_cnt);
    w_sum_nxt = sat_add(r_sum, in_data);
    w_max_nxt = (in_data > r_max) ? in_data : r_max;
    w_nzp_nxt = r_nzp ^ (in_data != '0);
    w_first   = (r_cnt == '0);
    w_mode    = w_first ? cfg_mode  : r_mode;
    w_bound   = w_first ? cfg_bound : r_bound;
    w_err     = (w_cnt_nxt != CNT_W'(NUM_VARS));
    w_x       = 1'b1;
    case (w_mode)
      2'd0:    w_x = 1'b1;
      2'd1:    w_x = (SUM_W'(w_max_nxt) <= w_bound);
      2'd2:    w_x = (w_sum_nxt <= w_bound);
      default: w_x = ~w_nzp_nxt;
    endcase
    if (w_err) w_x = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_COLLECT;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_max   <= '0;
      r_nzp   <= 1'b0;
      r_mode  <= '0;
      r_bound <= '0;
      r_x     <= 1'b0;
      r_err   <= 1'b0;
      r_count <= '0;
    end else begin
      case (r_state)
        S_COLLECT: begin
          if (in_valid) begin
            if (w_first) begin
              r_mode  <= cfg_mode;
              r_bound <= cfg_bound;
            end
            if (in_last) begin
              r_x     <= w_x;
              r_err   <= w_err;
              r_count <= w_cnt_nxt;
              r_cnt   <= '0;
              r_sum   <= '0;
              r_max   <= '0;
              r_nzp   <= 1'b0;
              r_state <= S_HOLD;
            end else begin
              r_cnt <= w_cnt_nxt;
              r_sum <= w_sum_nxt;
              r_max <= w_max_nxt;
              r_nzp <= w_nzp_nxt;
            end
          end
        end
        S_HOLD: begin
          if (out_ready) r_state <= S_COLLECT;
        end
        default: r_state <= S_COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_split_stream_checker.sv
// Bench for split_stream_checker with NUM_VARS=4: table of frames plus hand-written
// sequences for backpressure, mid-frame reset and counter saturation.
module tb_split_stream_checker;

  localparam int NV    = 4;
  localparam int DW    = 8;
  localparam int CW    = 4;   // $clog2(5)+1
  localparam int SW    = 11;  // 8+$clog2(4)+1

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    cfg_mode;
  logic [SW-1:0] cfg_bound;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic          out_x;
  logic          out_err;
  logic [CW-1:0] out_count;

  split_stream_checker #(.NUM_VARS(NV), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_bound(cfg_bound),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_err(out_err),
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]      mode;
    logic [SW-1:0]   bound;
    int              n;
    logic [0:5][7:0] d;
    logic            x;
    logic            err;
    logic [CW-1:0]   cnt;
  } vec_t;

  typedef struct packed {
    logic          x;
    logic          err;
    logic [CW-1:0] cnt;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int m, input int b, input int n,
                              input int d0, input int d1, input int d2,
                              input int d3, input int d4, input int d5,
                              input int x, input int e, input int c);
    vec_t v;
    v.mode  = 2'(m);
    v.bound = SW'(b);
    v.n     = n;
    v.d     = {8'(d0), 8'(d1), 8'(d2), 8'(d3), 8'(d4), 8'(d5)};
    v.x     = 1'(x);
    v.err   = 1'(e);
    v.cnt   = CW'(c);
    return v;
  endfunction

  // Scoreboard check on every verdict handshake
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_verdict", 32'(out_valid), 32'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("verdict_x", 32'(out_x), 32'(e.x));
        chk("verdict_err", 32'(out_err), 32'(e.err));
        chk("verdict_count", 32'(out_count), 32'(e.cnt));
      end
    end
  end

  task automatic send_beat(input logic [7:0] d, input logic l);
    int k = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) chk("beat_accept_timeout", 32'(in_ready), 32'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    in_last  = 1'($urandom);
  endtask

  task automatic wait_drain();
    int k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(posedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      chk("verdict_timeout", 32'(sb.size()), 32'(0));
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input vec_t v);
    exp_t e;
    cfg_mode  = v.mode;
    cfg_bound = v.bound;
    e.x = v.x; e.err = v.err; e.cnt = v.cnt;
    sb.push_back(e);
    for (int j = 0; j < v.n; j++) send_beat(v.d[j], (j == v.n - 1));
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cfg_mode = '0; cfg_bound = '0; in_valid = 1'b0; in_data = '0;
    in_last = 1'b0; out_ready = 1'b1;

    //        mode bound n   d0  d1  d2  d3 d4 d5   x err cnt
    tbl.push_back(mk(0, 0,    4,  1,  2,  3,  4, 0, 0,  1, 0, 4));
    tbl.push_back(mk(2, 10,   4,  1,  2,  3,  4, 0, 0,  1, 0, 4));
    tbl.push_back(mk(2, 10,   4,  1,  2,  3,  5, 0, 0,  0, 0, 4));
    tbl.push_back(mk(2, 2047, 4, 255,255,255,255,0, 0,  1, 0, 4));
    tbl.push_back(mk(1, 7,    4,  0,  7,  3,  2, 0, 0,  1, 0, 4));
    tbl.push_back(mk(1, 7,    4,  0,  8,  0,  0, 0, 0,  0, 0, 4));
    tbl.push_back(mk(0, 0,    3,  1,  2,  3,  0, 0, 0,  0, 1, 3));
    tbl.push_back(mk(0, 0,    6,  1,  2,  3,  4, 5, 6,  0, 1, 6));
    tbl.push_back(mk(3, 0,    4,  1,  0,  0,  0, 0, 0,  0, 0, 4));
    tbl.push_back(mk(3, 0,    4,  6,  6,  0,  0, 0, 0,  1, 0, 4));
    tbl.push_back(mk(1, 9,    4,  9,  9,  9,  9, 0, 0,  1, 0, 4));
    tbl.push_back(mk(2, 9,    4,  1,  2,  3,  4, 0, 0,  0, 0, 4));
    tbl.push_back(mk(0, 0,    1,  7,  0,  0,  0, 0, 0,  0, 1, 1));

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_x", 32'(out_x), 32'(0));
    chk("rst_out_err", 32'(out_err), 32'(0));
    chk("rst_out_count", 32'(out_count), 32'(0));
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++) send_frame(tbl[i]);

    // Backpressure with config changed mid-frame: mode2 bound 10 over 1,2,3,5 -> x=0
    out_ready = 1'b0;
    cfg_mode = 2'd2; cfg_bound = SW'(10);
    sb.push_back('{x: 1'b0, err: 1'b0, cnt: CW'(4)});
    send_beat(8'd1, 1'b0);
    cfg_mode = 2'd3; cfg_bound = SW'(100);
    send_beat(8'd2, 1'b0);
    send_beat(8'd3, 1'b0);
    send_beat(8'd5, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'(1));
      chk("bp_in_ready", 32'(in_ready), 32'(0));
      chk("bp_out_x", 32'(out_x), 32'(0));
      chk("bp_out_err", 32'(out_err), 32'(0));
      chk("bp_out_count", 32'(out_count), 32'(4));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bubble_out_valid", 32'(out_valid), 32'(0));
    chk("bubble_in_ready", 32'(in_ready), 32'(1));
    chk("bubble_count_held", 32'(out_count), 32'(4));
    wait_drain();

    // Reset after two beats: no verdict, then a clean mode3 frame
    cfg_mode = 2'd0; cfg_bound = '0;
    send_beat(8'd1, 1'b0);
    send_beat(8'd2, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("midrst_out_valid", 32'(out_valid), 32'(0));
      chk("midrst_in_ready", 32'(in_ready), 32'(1));
    end
    chk("midrst_out_count", 32'(out_count), 32'(0));
    @(posedge clk); #1;
    send_frame(mk(3, 0, 4, 0, 5, 0, 9, 0, 0, 1, 0, 4));

    // 18-beat frame: beat counter and sum both saturate, flagged as length error
    cfg_mode = 2'd2; cfg_bound = SW'(2047);
    sb.push_back('{x: 1'b0, err: 1'b1, cnt: CW'(15)});
    for (int j = 0; j < 18; j++) send_beat(8'd255, (j == 17));
    wait_drain();

    // Following frame must start from cleared accumulators
    send_frame(mk(1, 3, 4, 1, 3, 2, 0, 0, 0, 1, 0, 4));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
